// File: rtl/sdes_core_ctrl.sv
// Iterative S-DES encrypt/decrypt engine: one shared Feistel round, subkey
// generation with a one-entry key cache, valid/ready on both sides.

module S0_Box (
    input  logic [0:3] din,
    output logic [0:1] dout
);
    localparam logic [1:0] TBL [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                        2'd3, 2'd2, 2'd1, 2'd0,
                                        2'd0, 2'd2, 2'd1, 2'd3,
                                        2'd3, 2'd1, 2'd3, 2'd2};
    // Row comes from the outer bits, column from the inner bits.
    assign dout = TBL[{din[0], din[3], din[1], din[2]}];
endmodule

module S1_Box (
    input  logic [0:3] din,
    output logic [0:1] dout
);
    localparam logic [1:0] TBL [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                        2'd2, 2'd0, 2'd1, 2'd3,
                                        2'd3, 2'd0, 2'd1, 2'd0,
                                        2'd2, 2'd1, 2'd0, 2'd3};
    assign dout = TBL[{din[0], din[3], din[1], din[2]}];
endmodule

module sdes_core_ctrl #(
    parameter bit KEY_REUSE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mode,
    input  logic [0:9] key_in,
    input  logic [0:7] data_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [0:7] data_out,
    output logic       busy,
    output logic       key_hit
);
    typedef enum logic [2:0] {IDLE, KEY, RND1, RND2, DONE} state_t;

    state_t     state;
    logic       mode_reg;
    logic       cache_valid;
    logic [0:9] key_reg;
    logic [0:9] cache_key;
    logic [0:7] k1;
    logic [0:7] k2;
    logic [0:7] data_reg;

    logic [0:9] p10_key;
    logic [0:4] ls1_l, ls1_r, ls2_l, ls2_r;
    logic [0:7] round_key;
    logic [0:7] ep;
    logic [0:7] sbox_in;
    logic [0:1] s0_out, s1_out;
    logic [0:3] p4_in, p4_out;
    logic [0:7] fk_out;

    function automatic logic [0:7] p8(input logic [0:9] k);
        return {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
    endfunction

    function automatic logic [0:7] ip(input logic [0:7] d);
        return {d[1], d[5], d[2], d[0], d[3], d[7], d[4], d[6]};
    endfunction

    function automatic logic [0:7] ip_inv(input logic [0:7] d);
        return {d[3], d[0], d[2], d[4], d[6], d[1], d[7], d[5]};
    endfunction

    // Subkeys derive from the latched key; they are only captured in KEY.
    assign p10_key = {key_reg[2], key_reg[4], key_reg[1], key_reg[6], key_reg[3],
                      key_reg[9], key_reg[0], key_reg[8], key_reg[7], key_reg[5]};
    assign ls1_l   = {p10_key[1:4], p10_key[0]};
    assign ls1_r   = {p10_key[6:9], p10_key[5]};
    assign ls2_l   = {ls1_l[2:4], ls1_l[0:1]};
    assign ls2_r   = {ls1_r[2:4], ls1_r[0:1]};

    // Encrypt uses K1 then K2; decrypt reverses the order.
    assign round_key = ((state == RND2) ^ mode_reg) ? k2 : k1;
    assign ep        = {data_reg[7], data_reg[4], data_reg[5], data_reg[6],
                        data_reg[5], data_reg[6], data_reg[7], data_reg[4]};
    assign sbox_in   = ep ^ round_key;

    S0_Box u_s0 (.din(sbox_in[0:3]), .dout(s0_out));
    S1_Box u_s1 (.din(sbox_in[4:7]), .dout(s1_out));

    assign p4_in  = {s0_out, s1_out};
    assign p4_out = {p4_in[1], p4_in[3], p4_in[2], p4_in[0]};
    assign fk_out = {data_reg[0:3] ^ p4_out, data_reg[4:7]};

    // Control, handshakes and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            data_out    <= '0;
            busy        <= 1'b0;
            key_hit     <= 1'b0;
            cache_valid <= 1'b0;
            cache_key   <= '0;
            key_reg     <= '0;
            mode_reg    <= 1'b0;
            k1          <= '0;
            k2          <= '0;
            data_reg    <= '0;
        end else begin
            key_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mode_reg <= mode;
                        key_reg  <= key_in;
                        data_reg <= ip(data_in);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (KEY_REUSE && cache_valid && (key_in == cache_key)) begin
                            key_hit <= 1'b1;
                            state   <= RND1;
                        end else begin
                            state <= KEY;
                        end
                    end
                end
                KEY: begin
                    k1          <= p8({ls1_l, ls1_r});
                    k2          <= p8({ls2_l, ls2_r});
                    cache_key   <= key_reg;
                    cache_valid <= 1'b1;
                    state       <= RND1;
                end
                RND1: begin
                    data_reg <= {fk_out[4:7], fk_out[0:3]};
                    state    <= RND2;
                end
                RND2: begin
                    data_out  <= ip_inv(fk_out);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdes_core_ctrl.sv
// Scoreboard bench for sdes_core_ctrl: one instance with key reuse, one without,
// results compared against a table-driven S-DES software model.

module tb_sdes_core_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid0, in_valid1;
    logic       mode;
    logic       out_ready;
    logic [9:0] key_in;
    logic [7:0] data_in;

    logic       in_ready0, out_valid0, busy0, key_hit0;
    logic       in_ready1, out_valid1, busy1, key_hit1;
    logic [7:0] data_out0, data_out1;

    logic       sel;
    logic       s_in_ready, s_out_valid, s_busy, s_key_hit;
    logic [7:0] s_data_out;

    int         n_checks = 0;
    int         n_pass = 0;
    int         hit1_count = 0;
    logic [7:0] sb[$];

    localparam logic [9:0] KEY_A = 10'b1010000010;

    localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    localparam int IP_T  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    localparam int IPI_T [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    localparam int EP_T  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    localparam int P4_T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    localparam int S0_T  [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
    localparam int S1_T  [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

    always #5 clk = ~clk;

    sdes_core_ctrl #(.KEY_REUSE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .mode(mode), .key_in(key_in), .data_in(data_in), .out_valid(out_valid0),
        .out_ready(out_ready), .data_out(data_out0), .busy(busy0), .key_hit(key_hit0)
    );

    sdes_core_ctrl #(.KEY_REUSE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .mode(mode), .key_in(key_in), .data_in(data_in), .out_valid(out_valid1),
        .out_ready(out_ready), .data_out(data_out1), .busy(busy1), .key_hit(key_hit1)
    );

    assign s_in_ready  = sel ? in_ready1  : in_ready0;
    assign s_out_valid = sel ? out_valid1 : out_valid0;
    assign s_busy      = sel ? busy1      : busy0;
    assign s_key_hit   = sel ? key_hit1   : key_hit0;
    assign s_data_out  = sel ? data_out1  : data_out0;

    always @(posedge clk) if (key_hit1) hit1_count <= hit1_count + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Position p in a table picks textbook bit p (bit 1 = MSB) of an n_in-bit input.
    function automatic logic [9:0] permute(input logic [9:0] v, input int n_in,
                                           input int n_out, input int tbl [10]);
        logic [9:0] res;
        res = '0;
        for (int i = 0; i < n_out; i++) res[n_out-1-i] = v[n_in-tbl[i]];
        return res;
    endfunction

    function automatic logic [1:0] sbox_model(input bit second, input logic [3:0] x);
        int idx;
        idx = {x[3], x[0]} * 4 + {x[2], x[1]};
        return second ? 2'(S1_T[idx]) : 2'(S0_T[idx]);
    endfunction

    function automatic logic [7:0] fk_model(input logic [7:0] x, input logic [7:0] k);
        logic [9:0] t;
        logic [7:0] e;
        logic [3:0] s;
        t = permute({6'b0, x[3:0]}, 4, 8, EP_T);
        e = t[7:0] ^ k;
        s = {sbox_model(1'b0, e[7:4]), sbox_model(1'b1, e[3:0])};
        t = permute({6'b0, s}, 4, 4, P4_T);
        return {x[7:4] ^ t[3:0], x[3:0]};
    endfunction

    function automatic logic [7:0] sdes_model(input logic [9:0] key, input logic [7:0] pt,
                                              input logic dec);
        logic [9:0] p, t;
        logic [4:0] l1, r1, l2, r2;
        logic [7:0] k1, k2, a, b;
        p  = permute(key, 10, 10, P10_T);
        l1 = {p[8:5], p[9]};
        r1 = {p[3:0], p[4]};
        t  = permute({l1, r1}, 10, 8, P8_T);
        k1 = t[7:0];
        l2 = {l1[2:0], l1[4:3]};
        r2 = {r1[2:0], r1[4:3]};
        t  = permute({l2, r2}, 10, 8, P8_T);
        k2 = t[7:0];
        t  = permute({2'b0, pt}, 8, 8, IP_T);
        a  = fk_model(t[7:0], dec ? k2 : k1);
        a  = {a[3:0], a[7:4]};
        b  = fk_model(a, dec ? k1 : k2);
        t  = permute({2'b0, b}, 8, 8, IPI_T);
        return t[7:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    task automatic set_valid(input logic v);
        if (sel) in_valid1 = v;
        else     in_valid0 = v;
    endtask

    // One transaction: drive, push expectation, measure latency, hold backpressure, pop and compare.
    task automatic applyStimulus(input logic which, input logic [9:0] key, input logic [7:0] data,
                                 input logic m, input logic [7:0] exp_data,
                                 input logic exp_hit, input int exp_lat, input int bp_cycles);
        int edges;
        logic [7:0] exp_pop;
        @(negedge clk);
        sel = which;
        #1;
        checkOutput("in_ready_idle", 32'(s_in_ready), 32'd1);
        key_in    = key;
        data_in   = data;
        mode      = m;
        out_ready = (bp_cycles == 0);
        set_valid(1'b1);
        sb.push_back(exp_data);
        @(posedge clk);
        #1;
        set_valid(1'b0);
        key_in  = ~key;
        data_in = ~data;
        mode    = ~m;
        checkOutput("key_hit", 32'(s_key_hit), 32'(exp_hit));
        checkOutput("busy_run", 32'(s_busy), 32'd1);
        checkOutput("in_ready_run", 32'(s_in_ready), 32'd0);
        edges = 0;
        while (!s_out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            set_valid(edges[0]);
        end
        set_valid(1'b0);
        checkOutput("latency", 32'(edges), 32'(exp_lat));
        for (int i = 0; i < bp_cycles; i++) begin
            checkOutput("bp_data", 32'(s_data_out), 32'(exp_data));
            checkOutput("bp_valid", 32'(s_out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(s_in_ready), 32'd0);
            checkOutput("bp_busy", 32'(s_busy), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 32'd0, 32'd1);
        end else begin
            exp_pop = sb.pop_front();
            checkOutput("data_out", 32'(s_data_out), 32'(exp_pop));
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid_drop", 32'(s_out_valid), 32'd0);
        checkOutput("in_ready_back", 32'(s_in_ready), 32'd1);
        checkOutput("busy_idle", 32'(s_busy), 32'd0);
    endtask

    initial begin
        logic [9:0] cache_key;
        logic [9:0] k;
        logic [7:0] d;
        logic       m;
        logic       hit;

        sel       = 1'b0;
        rst_n     = 1'b0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        mode      = 1'b0;
        key_in    = '0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready0), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("rst_data_out", 32'(data_out0), 32'd0);
        checkOutput("rst_busy", 32'(busy0), 32'd0);
        checkOutput("rst_key_hit", 32'(key_hit0), 32'd0);
        rst_n = 1'b1;

        // Abort mid-RND1: the cache was just filled, reset must wipe it.
        @(negedge clk);
        key_in    = KEY_A;
        data_in   = 8'b10010111;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready0), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("abort_data_out", 32'(data_out0), 32'd0);
        checkOutput("abort_busy", 32'(busy0), 32'd0);
        checkOutput("abort_key_hit", 32'(key_hit0), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_no_output", 32'(out_valid0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] encrypt, decrypt with reuse, backpressure");
        applyStimulus(1'b0, KEY_A, 8'b10010111, 1'b0, 8'b00111000, 1'b0, 3, 0);
        applyStimulus(1'b0, KEY_A, 8'b00111000, 1'b1, 8'b10010111, 1'b1, 2, 0);
        applyStimulus(1'b0, KEY_A, 8'b10010111, 1'b0, 8'b00111000, 1'b1, 2, 6);

        $display("[TB] key change");
        applyStimulus(1'b0, 10'h3FF, 8'b10010111, 1'b0,
                      sdes_model(10'h3FF, 8'b10010111, 1'b0), 1'b0, 3, 0);
        cache_key = 10'h3FF;

        $display("[TB] random traffic");
        for (int i = 0; i < 6; i++) begin
            k   = i[0] ? 10'($urandom_range(0, 1023)) : ((i == 2) ? cache_key : KEY_A);
            d   = 8'($urandom_range(0, 255));
            m   = 1'($urandom_range(0, 1));
            hit = (k == cache_key);
            applyStimulus(1'b0, k, d, m, sdes_model(k, d, m), hit, hit ? 2 : 3, i % 3);
            cache_key = k;
        end

        $display("[TB] no key reuse");
        applyStimulus(1'b1, KEY_A, 8'b10010111, 1'b0, 8'b00111000, 1'b0, 3, 0);
        applyStimulus(1'b1, KEY_A, 8'b00111000, 1'b1, 8'b10010111, 1'b0, 3, 0);
        applyStimulus(1'b1, KEY_A, 8'b01010101, 1'b0,
                      sdes_model(KEY_A, 8'b01010101, 1'b0), 1'b0, 3, 2);
        checkOutput("noreuse_hit_count", 32'(hit1_count), 32'd0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sdes_core_ctrl.md
Name: sdes_core_ctrl

Overview:
Iterative S-DES encrypt/decrypt engine built around one shared round function. It instantiates S0_Box and S1_Box once each, generates subkeys K1/K2 from a 10-bit key, and sequences IP, two Feistel rounds and IP^-1 through an FSM. It accepts one 8-bit block per valid/ready transaction on its input and returns the result on a valid/ready output. It sits between the system bus adapter and the cipher datapath.

Parameters:
KEY_REUSE, 1, when 1, an accepted key equal to the cached expanded key skips the KEY state (saves 1 cycle); when 0, the KEY state always runs.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request carries a valid block/key/mode
in_ready  output  1  engine can accept; high only in IDLE
mode  input  1  0 = encrypt (K1 then K2), 1 = decrypt (K2 then K1)
key_in  input  [0:9]  10-bit key, bit 0 = textbook bit 1 (MSB)
data_in  input  [0:7]  plaintext/ciphertext block, bit 0 = MSB
out_valid  output  1  data_out is valid; held until out_ready
out_ready  input  1  consumer accepts data_out
data_out  output  [0:7]  result block, stable while out_valid
busy  output  1  high in any state other than IDLE
key_hit  output  1  one-cycle pulse on acceptance when the cached key is reused

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1, out_valid=0, data_out=8'h00, busy=0, key_hit=0; key cache invalid; K1/K2/data registers cleared. Reset asserted mid-operation aborts the block with no output.
- All permutations use 1-based textbook positions mapped to bit index-1:
  P10=3 5 2 7 4 10 1 9 8 6; P8=6 3 7 4 8 5 10 9; IP=2 6 3 1 4 8 5 7; IP^-1=4 1 3 5 7 2 8 6; EP=4 1 2 3 2 3 4 1; P4=2 4 3 1.
- Subkeys: K1=P8(LS1 of both 5-bit halves of P10(key)); K2=P8(LS2 applied to the halves from the LS1 step).
- fk(L,R,K) = {L ^ P4({S0(EP(R)[0:3]^K[0:3]), S1(EP(R)[4:7]^K[4:7])}), R}. SW swaps the 4-bit halves. S-box inputs are the raw 4 bits; row/column decoding is internal to the S-boxes.
- FSM: IDLE -> KEY -> RND1 -> RND2 -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch mode and key, and latch data_reg=IP(data_in).
  - If KEY_REUSE=1, the cache is valid and key_in equals the cached key: pulse key_hit and go to RND1.
  - Otherwise go to KEY.
- KEY (1 cycle): register K1 and K2, store the key in the cache, set cache valid.
- RND1 (1 cycle): data_reg <= SW(fk(data_reg, mode ? K2 : K1)).
- RND2 (1 cycle): data_out <= IP^-1(fk(data_reg, mode ? K1 : K2)); out_valid <= 1; go to DONE.
- DONE: hold out_valid and data_out. When out_ready=1, clear out_valid at the next edge and return to IDLE. in_ready stays 0 until IDLE, so there is no overlap and no back-to-back acceptance in the DONE-exit cycle.
- Latency from the accepting edge to out_valid=1:
  - 3 edges on the KEY path (KEY, RND1, RND2).
  - 2 edges on the key-reuse path.
- Minimum initiation interval is 5 cycles (KEY path) or 4 cycles (reuse path), each with out_ready held high.
- Inputs are ignored outside IDLE. A toggling in_valid during processing has no effect.
- out_ready asserted while out_valid=0 has no effect.
- The key cache survives across transactions and is cleared only by reset. A mode change does not invalidate it.

Test Plan:
- Reset: hold rst_n=0 mid-RND1 -> all outputs return to reset values immediately; after release, the next request with key 1010000010 takes the KEY path (key_hit=0).
- Encrypt: key=1010000010, data=10010111, mode=0, out_ready=1 -> internal K1=10100100, K2=01000011; data_out=00111000, out_valid 3 edges after accept, key_hit=0.
- Decrypt with reuse (KEY_REUSE=1): next request key=1010000010, data=00111000, mode=1 -> key_hit pulses on acceptance, out_valid 2 edges later, data_out=10010111.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> data_out stays 00111000, in_ready=0, busy=1 throughout; out_ready=1 -> out_valid drops next edge, in_ready=1.
- Key change: key=1111111111 after a cached 1010000010 -> KEY state runs, key_hit=0; the result matches the software model for data 10010111.
- KEY_REUSE=0: the repeated-key request still runs KEY, latency 3, key_hit never asserts.
